// File: rtl/fpu_ss_pkg.sv
// Shared types for the FPU subsystem issue path: predecoder request/response,
// issue FSM states and the one-entry issue register layout.
package fpu_ss_pkg;

  localparam int unsigned FPU_INSTR_W = 32;
  localparam int unsigned FPU_ID_W    = 4;
  localparam int unsigned FPU_REG_W   = 32;

  localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    DISPATCH
  } issue_state_e;

  typedef struct packed {
    logic [31:0] q_instr_data;
  } acc_prd_req_t;

  typedef struct packed {
    logic       p_accept;
    logic       p_writeback;
    logic       p_is_mem_op;
    logic [2:0] p_use_rs;
  } acc_prd_rsp_t;

  typedef struct packed {
    logic [FPU_INSTR_W-1:0]         instr;
    logic [FPU_ID_W-1:0]            id;
    logic [2:0][FPU_REG_W-1:0]      rs;
    logic                           is_mem;
  } issue_reg_t;

  function automatic logic is_system_op(input logic [6:0] opcode);
    return opcode == OPCODE_SYSTEM;
  endfunction

endpackage

// File: rtl/fpu_ss_inflight_cnt.sv
// Up/down counter of dispatched-but-uncompleted ops, clamped to [0, MAX_VAL].
// Count visible one cycle after inc/dec; simultaneous inc and dec cancel.
module fpu_ss_inflight_cnt #(
  parameter int unsigned MAX_VAL = 4,
  parameter int unsigned CNT_W   = $clog2(MAX_VAL + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_VAL);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (inc_i && !dec_i) begin
      if (cnt_q != MAX_CNT) cnt_q <= cnt_q + 1'b1;
    end else if (dec_i && !inc_i) begin
      // a stray completion with nothing outstanding is dropped
      if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fpu_ss_issue_ctrl.sv
// Offload q-channel to instruction-buffer issue sequencer; k_* are 0-cycle pass-through, dispatch 1 cycle after accept.
// Backpressure: q_ready low outside IDLE, at MAX_INFLIGHT or on a second mem op; optional FPU_SS_ISSUE_STALL_CNT_EN.
module fpu_ss_issue_ctrl
  import fpu_ss_pkg::*;
#(
  parameter int unsigned INSTR_W      = FPU_INSTR_W,
  parameter int unsigned ID_W         = FPU_ID_W,
  parameter int unsigned REG_W        = FPU_REG_W,
  parameter int unsigned MAX_INFLIGHT = 4,
  localparam int unsigned CNT_W       = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  q_valid_i,
  output logic                  q_ready_o,
  input  logic [INSTR_W-1:0]    q_instr_i,
  input  logic [ID_W-1:0]       q_id_i,
  input  logic [2:0][REG_W-1:0] q_rs_i,
  output logic                  k_accept_o,
  output logic                  k_writeback_o,
  output logic                  k_is_mem_op_o,
  output logic [2:0]            k_use_rs_o,
  output acc_prd_req_t          prd_req_o,
  input  acc_prd_rsp_t          prd_rsp_i,
  output logic                  disp_valid_o,
  input  logic                  disp_ready_i,
  output logic [INSTR_W-1:0]    disp_instr_o,
  output logic [ID_W-1:0]       disp_id_o,
  output logic [2:0][REG_W-1:0] disp_rs_o,
  output logic                  disp_is_mem_o,
  input  logic                  op_done_i,
  input  logic                  mem_done_i,
  output logic [CNT_W-1:0]      inflight_o,
  output logic                  busy_o
`ifdef FPU_SS_ISSUE_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cnt_o
`endif
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

  issue_state_e          state_q;
  issue_reg_t            issue_q;
  logic                  disp_valid_q;
  logic                  mem_pend_q;
  logic [CNT_W-1:0]      inflight;
  logic                  q_hs;
  logic                  acc_hs;
  logic                  disp_hs;
  logic                  is_csr;
  logic [2:0][REG_W-1:0] rs_masked;

  assign prd_req_o.q_instr_data = q_instr_i;

  assign q_ready_o = (state_q == IDLE) && (inflight < MAX_CNT)
                     && !(prd_rsp_i.p_is_mem_op && mem_pend_q);

  assign q_hs    = q_valid_i && q_ready_o;
  assign acc_hs  = q_hs && prd_rsp_i.p_accept;
  assign disp_hs = disp_valid_q && disp_ready_i;
  assign is_csr  = is_system_op(q_instr_i[6:0]);

  // Response fields only mean something in the handshake cycle; keep them quiet otherwise.
  assign k_accept_o    = q_hs && prd_rsp_i.p_accept;
  assign k_writeback_o = q_hs && prd_rsp_i.p_writeback;
  assign k_is_mem_op_o = q_hs && prd_rsp_i.p_is_mem_op;
  assign k_use_rs_o    = q_hs ? prd_rsp_i.p_use_rs : 3'b000;

  always_comb begin
    rs_masked = '0;
    for (int l = 0; l < 3; l++) begin
      if (prd_rsp_i.p_use_rs[l]) rs_masked[l] = q_rs_i[l];
    end
  end

  // CSR instructions may change rounding/flags, so they wait for the pipe to empty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      issue_q      <= '0;
      disp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (acc_hs) begin
            issue_q.instr  <= q_instr_i;
            issue_q.id     <= q_id_i;
            issue_q.rs     <= rs_masked;
            issue_q.is_mem <= prd_rsp_i.p_is_mem_op;
            if (is_csr && (inflight != '0)) begin
              state_q <= DRAIN;
            end else begin
              state_q      <= DISPATCH;
              disp_valid_q <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (inflight == '0) begin
            state_q      <= DISPATCH;
            disp_valid_q <= 1'b1;
          end
        end
        DISPATCH: begin
          if (disp_hs) begin
            state_q      <= IDLE;
            disp_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          disp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_pend_q <= 1'b0;
    end else if (disp_hs && issue_q.is_mem) begin
      mem_pend_q <= 1'b1;
    end else if (mem_done_i) begin
      mem_pend_q <= 1'b0;
    end
  end

  fpu_ss_inflight_cnt #(
    .MAX_VAL (MAX_INFLIGHT),
    .CNT_W   (CNT_W)
  ) u_inflight_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (disp_hs),
    .dec_i (op_done_i),
    .cnt_o (inflight)
  );

`ifdef FPU_SS_ISSUE_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if (q_valid_i && !q_ready_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

  assign disp_valid_o  = disp_valid_q;
  assign disp_instr_o  = issue_q.instr;
  assign disp_id_o     = issue_q.id;
  assign disp_rs_o     = issue_q.rs;
  assign disp_is_mem_o = issue_q.is_mem;
  assign inflight_o    = inflight;
  assign busy_o        = (state_q != IDLE) || (inflight != '0);

endmodule

// File: tb/tb_fpu_ss_issue_ctrl.sv
// Directed bench for fpu_ss_issue_ctrl with a local predecoder model and a dispatch scoreboard.
module tb_fpu_ss_issue_ctrl;
  import fpu_ss_pkg::*;

  localparam logic [31:0] I_FADD = 32'h0031_00D3;
  localparam logic [31:0] I_FLW  = 32'h0005_2087;
  localparam logic [31:0] I_FSW  = 32'h0025_A227;
  localparam logic [31:0] I_CSR  = 32'h0032_9073;

  logic             clk = 1'b0;
  logic             rst;
  logic             q_valid, q_ready;
  logic [31:0]      q_instr;
  logic [3:0]       q_id;
  logic [2:0][31:0] q_rs;
  logic             k_accept, k_writeback, k_is_mem_op;
  logic [2:0]       k_use_rs;
  acc_prd_req_t     prd_req;
  acc_prd_rsp_t     prd_rsp;
  logic             disp_valid, disp_ready;
  logic [31:0]      disp_instr;
  logic [3:0]       disp_id;
  logic [2:0][31:0] disp_rs;
  logic             disp_is_mem;
  logic             op_done, mem_done;
  logic [2:0]       inflight;
  logic             busy;

  int n_assert = 0;
  int n_fail   = 0;
  issue_reg_t sb[$];

  always #5 clk = ~clk;

  fpu_ss_issue_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .q_valid_i(q_valid), .q_ready_o(q_ready), .q_instr_i(q_instr), .q_id_i(q_id), .q_rs_i(q_rs),
    .k_accept_o(k_accept), .k_writeback_o(k_writeback), .k_is_mem_op_o(k_is_mem_op), .k_use_rs_o(k_use_rs),
    .prd_req_o(prd_req), .prd_rsp_i(prd_rsp),
    .disp_valid_o(disp_valid), .disp_ready_i(disp_ready), .disp_instr_o(disp_instr), .disp_id_o(disp_id),
    .disp_rs_o(disp_rs), .disp_is_mem_o(disp_is_mem),
    .op_done_i(op_done), .mem_done_i(mem_done), .inflight_o(inflight), .busy_o(busy)
  );

  function automatic acc_prd_rsp_t decode(input logic [31:0] i);
    acc_prd_rsp_t r;
    r = '0;
    case (i[6:0])
      7'b1010011: r.p_accept = 1'b1;
      7'b0000111, 7'b0100111: if (i[14:12] == 3'b010) begin
        r.p_accept = 1'b1; r.p_is_mem_op = 1'b1; r.p_use_rs = 3'b001;
      end
      7'b1110011: if (i[14:12] != 3'b000) begin
        r.p_accept = 1'b1; r.p_writeback = 1'b1; r.p_use_rs = 3'b001;
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb prd_rsp = decode(prd_req.q_instr_data);

  function automatic issue_reg_t expect_of(input logic [31:0] i, input logic [3:0] id,
                                           input logic [2:0][31:0] rs);
    acc_prd_rsp_t r;
    issue_reg_t e;
    r = decode(i);
    e.instr = i;
    e.id = id;
    e.is_mem = r.p_is_mem_op;
    for (int l = 0; l < 3; l++) e.rs[l] = r.p_use_rs[l] ? rs[l] : 32'h0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] i, input logic [3:0] id, input logic [2:0][31:0] rs);
    acc_prd_rsp_t r;
    tick();
    q_valid = 1'b1; q_instr = i; q_id = id; q_rs = rs;
    r = decode(i);
    if (r.p_accept) sb.push_back(expect_of(i, id, rs));
    @(negedge clk);
    chk("offer_q_ready", q_ready, 1);
    chk("offer_k_accept", k_accept, r.p_accept);
    chk("offer_k_writeback", k_writeback, r.p_writeback);
    chk("offer_k_use_rs", k_use_rs, r.p_use_rs);
    tick();
    q_valid = 1'b0; q_instr = '0;
    @(negedge clk);
  endtask

  // Every dispatch handshake must match the oldest accepted instruction.
  always @(negedge clk) begin
    if (!rst && disp_valid && disp_ready) begin
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        issue_reg_t e;
        e = sb.pop_front();
        chk("disp_instr", disp_instr, e.instr);
        chk("disp_id", disp_id, e.id);
        chk("disp_rs", disp_rs, e.rs);
        chk("disp_is_mem", disp_is_mem, e.is_mem);
      end
    end
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; q_valid = 1'b0; q_instr = '0; q_id = '0; q_rs = '0;
    disp_ready = 1'b1; op_done = 1'b0; mem_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_q_ready", q_ready, 1);
    chk("rst_disp_valid", disp_valid, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_busy", busy, 0);
    chk("rst_k_accept", k_accept, 0);
    @(posedge clk); #1 rst = 1'b0;

    // FADD: accepted, dispatched the next cycle, inflight goes 0 -> 1
    offer(I_FADD, 4'd1, {32'hC, 32'hB, 32'hA});
    chk("t1_disp_valid", disp_valid, 1);
    chk("t1_inflight_before", inflight, 0);
    chk("t1_q_ready_dispatch", q_ready, 0);
    chk("t1_busy", busy, 1);
    tick(); @(negedge clk);
    chk("t1_disp_valid_after", disp_valid, 0);
    chk("t1_inflight_after", inflight, 1);
    op_done = 1'b1; tick(); op_done = 1'b0;
    @(negedge clk);
    chk("t1_inflight_done", inflight, 0);

    // Unknown instruction: handshake completes, nothing dispatched
    offer(32'h0, 4'd2, {32'h3, 32'h2, 32'h1});
    chk("t2_disp_valid", disp_valid, 0);
    chk("t2_inflight", inflight, 0);
    chk("t2_busy", busy, 0);

    // Fill to MAX_INFLIGHT, then one completion reopens the channel
    for (int k = 0; k < 4; k++) offer(I_FADD, 4'(k + 3), {32'h30, 32'h20, 32'(k)});
    tick();
    q_valid = 1'b1; q_instr = I_FADD; q_id = 4'd9;
    @(negedge clk);
    chk("t3_q_ready_full", q_ready, 0);
    chk("t3_inflight_full", inflight, 4);
    tick();
    q_valid = 1'b0; q_instr = '0; op_done = 1'b1;
    tick();
    op_done = 1'b0;
    @(negedge clk);
    chk("t3_inflight_3", inflight, 3);
    chk("t3_q_ready_reopen", q_ready, 1);
    tick(); op_done = 1'b1;
    repeat (3) tick();
    op_done = 1'b0;
    @(negedge clk);
    chk("t3_inflight_drained", inflight, 0);

    // FLW then FSW: second mem op stalls until mem_done
    offer(I_FLW, 4'd5, {32'h333, 32'h222, 32'h1000});
    chk("t4_flw_is_mem", disp_is_mem, 1);
    tick();
    q_valid = 1'b1; q_instr = I_FSW; q_id = 4'd6; q_rs = {32'h6, 32'h5, 32'h2000};
    @(negedge clk);
    chk("t4_fsw_stalled", q_ready, 0);
    tick(); mem_done = 1'b1;
    @(negedge clk);
    chk("t4_fsw_stalled_done", q_ready, 0);
    tick(); mem_done = 1'b0;
    sb.push_back(expect_of(I_FSW, 4'd6, {32'h6, 32'h5, 32'h2000}));
    @(negedge clk);
    chk("t4_fsw_ready", q_ready, 1);
    chk("t4_fsw_k_mem", k_is_mem_op, 1);
    tick(); q_valid = 1'b0; q_instr = '0;
    @(negedge clk);
    chk("t4_fsw_disp_valid", disp_valid, 1);
    chk("t4_fsw_disp_mem", disp_is_mem, 1);
    chk("t4_inflight", inflight, 1);
    tick(); op_done = 1'b1; mem_done = 1'b1;
    tick(); tick();
    op_done = 1'b0; mem_done = 1'b0;
    @(negedge clk);
    chk("t4_inflight_drained", inflight, 0);

    // CSR with two ops in flight waits in DRAIN
    offer(I_FADD, 4'd8, {32'h0, 32'h0, 32'h1});
    offer(I_FADD, 4'd9, {32'h0, 32'h0, 32'h2});
    offer(I_CSR, 4'd10, {32'hEE, 32'hDD, 32'h55});
    chk("t5_drain_disp_valid", disp_valid, 0);
    chk("t5_drain_inflight", inflight, 2);
    chk("t5_drain_busy", busy, 1);
    tick(); op_done = 1'b1;
    @(negedge clk);
    chk("t5_drain_wait1", disp_valid, 0);
    tick();
    @(negedge clk);
    chk("t5_drain_wait2", disp_valid, 0);
    tick(); op_done = 1'b0;
    @(negedge clk);
    chk("t5_drain_wait3", disp_valid, 0);
    chk("t5_drain_empty", inflight, 0);
    tick();
    @(negedge clk);
    chk("t5_csr_dispatched", disp_valid, 1);
    tick(); op_done = 1'b1;
    tick(); op_done = 1'b0;
    @(negedge clk);
    chk("t5_idle_busy", busy, 0);

    // Reset while DISPATCH is stalled by the buffer
    offer(I_FADD, 4'd11, {32'h0, 32'h0, 32'h7});
    tick();
    disp_ready = 1'b0;
    q_valid = 1'b1; q_instr = I_FADD; q_id = 4'd12; q_rs = {32'h0, 32'h0, 32'h8};
    sb.push_back(expect_of(I_FADD, 4'd12, {32'h0, 32'h0, 32'h8}));
    @(negedge clk);
    chk("t6_q_ready", q_ready, 1);
    tick(); q_valid = 1'b0; q_instr = '0;
    @(negedge clk);
    chk("t6_held_valid", disp_valid, 1);
    tick();
    @(negedge clk);
    chk("t6_held_valid2", disp_valid, 1);
    chk("t6_held_id", disp_id, 12);
    chk("t6_held_instr", disp_instr, I_FADD);
    chk("t6_inflight_pre", inflight, 1);
    tick();
    rst = 1'b1;
    #1;
    chk("t6_rst_disp_valid", disp_valid, 0);
    chk("t6_rst_inflight", inflight, 0);
    sb.delete();
    tick();
    rst = 1'b0; disp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t6_post_q_ready", q_ready, 1);
      chk("t6_post_disp_valid", disp_valid, 0);
      chk("t6_post_busy", busy, 0);
    end

    chk("sb_empty_end", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
